// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports and the dmem pins seen by dmem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/dmem side.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_q,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_address, mem_data, mem_wren
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_q,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous dmem between the processor
// port (0) and the debug/loader port (1), routing read data back to the issuing port.
module dmem_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input logic                clock,
    input logic                reset,
    dmem_port_arbiter_if.slave bus
);

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_badRdLat
            $error("dmem_port_arbiter: RD_LAT must be within 1..4");
        end
    endgenerate

    typedef enum logic {
        OWNER0 = 1'b0,
        OWNER1 = 1'b1
    } owner_e;

    owner_e            lastOwner_q, lastOwner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [RD_LAT-1:0] rdValid_q, rdValid_d;
    logic [RD_LAT-1:0] rdOwner_q, rdOwner_d;

    logic              gnt0;
    logic              gnt1;
    logic              granted;
    logic              grantWe;
    logic [ADDR_W-1:0] grantAddr;
    logic [DATA_W-1:0] grantData;
    logic              retValid;

    // On a conflict the port that did not win last time is served; reset blocks all grants.
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        lastOwner_d = lastOwner_q;
        if (!reset) begin
            if (bus.r0_req && bus.r1_req) begin
                gnt0 = (lastOwner_q == OWNER1);
                gnt1 = (lastOwner_q == OWNER0);
            end else begin
                gnt0 = bus.r0_req;
                gnt1 = bus.r1_req;
            end
        end
        if (gnt0) begin
            lastOwner_d = OWNER0;
        end else if (gnt1) begin
            lastOwner_d = OWNER1;
        end
    end

    always_comb begin
        granted   = gnt0 | gnt1;
        grantWe   = gnt1 ? bus.r1_we    : bus.r0_we;
        grantAddr = gnt1 ? bus.r1_addr  : bus.r0_addr;
        grantData = gnt1 ? bus.r1_wdata : bus.r0_wdata;
        addr_d    = granted ? grantAddr : addr_q;
        data_d    = granted ? grantData : data_q;

        // Read-ownership pipeline: stage 0 is this cycle's access, the last stage returns.
        rdValid_d    = '0;
        rdOwner_d    = '0;
        rdValid_d[0] = granted & ~grantWe;
        rdOwner_d[0] = gnt1;
        for (int i = 1; i < RD_LAT; i++) begin
            rdValid_d[i] = rdValid_q[i-1];
            rdOwner_d[i] = rdOwner_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lastOwner_q <= OWNER1;
            addr_q      <= '0;
            data_q      <= '0;
            rdValid_q   <= '0;
            rdOwner_q   <= '0;
        end else begin
            lastOwner_q <= lastOwner_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rdValid_q   <= rdValid_d;
            rdOwner_q   <= rdOwner_d;
        end
    end

    assign retValid = rdValid_q[RD_LAT-1] & ~reset;

    assign bus.r0_gnt      = gnt0;
    assign bus.r1_gnt      = gnt1;
    assign bus.mem_wren    = granted & grantWe;
    assign bus.mem_address = reset ? '0 : addr_d;
    assign bus.mem_data    = reset ? '0 : data_d;
    assign bus.r0_rvalid   = retValid & ~rdOwner_q[RD_LAT-1];
    assign bus.r1_rvalid   = retValid &  rdOwner_q[RD_LAT-1];
    assign bus.r0_rdata    = bus.mem_q;
    assign bus.r1_rdata    = bus.mem_q;

    grantOneHot: assert property (@(posedge clock) !(gnt0 && gnt1));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: RD_LAT=1 and RD_LAT=3 instances share stimulus and are
// compared each cycle against a queue-based model of grants, bus pins and read returns.
module tb_dmem_port_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } ret_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busA ();
    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busB ();

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dutA (
        .clock(clock), .reset(reset), .bus(busA.slave));
    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3)) dutB (
        .clock(clock), .reset(reset), .bus(busB.slave));

    assign busA.r0_req = req0;   assign busB.r0_req = req0;
    assign busA.r0_we = we0;     assign busB.r0_we = we0;
    assign busA.r0_addr = addr0; assign busB.r0_addr = addr0;
    assign busA.r0_wdata = wdata0; assign busB.r0_wdata = wdata0;
    assign busA.r1_req = req1;   assign busB.r1_req = req1;
    assign busA.r1_we = we1;     assign busB.r1_we = we1;
    assign busA.r1_addr = addr1; assign busB.r1_addr = addr1;
    assign busA.r1_wdata = wdata1; assign busB.r1_wdata = wdata1;

    function automatic logic [31:0] seedWord(input int a);
        logic [11:0] lo;
        lo = a[11:0];
        return {8'h5A, lo, ~lo};
    endfunction

    // Behavioural dmem per instance: synchronous, read-old, delayed to match RD_LAT.
    logic [DATA_W-1:0] memA [4096];
    logic [DATA_W-1:0] memB [4096];
    logic [DATA_W-1:0] qA, qB0, qB1, qB2;
    logic              memReady = 1'b0;

    always @(posedge clock) begin
        if (!memReady) begin
            for (int i = 0; i < 4096; i++) begin
                memA[i] <= seedWord(i);
                memB[i] <= seedWord(i);
            end
            memReady <= 1'b1;
        end else begin
            if (busA.mem_wren) memA[busA.mem_address] <= busA.mem_data;
            if (busB.mem_wren) memB[busB.mem_address] <= busB.mem_data;
        end
        qA  <= memA[busA.mem_address];
        qB0 <= memB[busB.mem_address];
        qB1 <= qB0;
        qB2 <= qB1;
    end
    assign busA.mem_q = qA;
    assign busB.mem_q = qB2;

    logic [4:0]        obsFlags [2];
    logic [ADDR_W-1:0] obsAddr  [2];
    logic [DATA_W-1:0] obsData  [2];
    logic [DATA_W-1:0] obsRd0   [2];
    logic [DATA_W-1:0] obsRd1   [2];
    assign obsFlags[0] = {busA.r0_gnt, busA.r1_gnt, busA.mem_wren, busA.r0_rvalid, busA.r1_rvalid};
    assign obsFlags[1] = {busB.r0_gnt, busB.r1_gnt, busB.mem_wren, busB.r0_rvalid, busB.r1_rvalid};
    assign obsAddr[0] = busA.mem_address; assign obsAddr[1] = busB.mem_address;
    assign obsData[0] = busA.mem_data;    assign obsData[1] = busB.mem_data;
    assign obsRd0[0] = busA.r0_rdata;     assign obsRd0[1] = busB.r0_rdata;
    assign obsRd1[0] = busA.r1_rdata;     assign obsRd1[1] = busB.r1_rdata;

    int                cyc       = 0;
    int                lastOwner = 1;
    logic [ADDR_W-1:0] holdAddr  = '0;
    logic [DATA_W-1:0] holdData  = '0;
    logic [DATA_W-1:0] refMem [4096];
    ret_t              retA[$];
    ret_t              retB[$];
    bit                curG0 = 1'b0, curG1 = 1'b0;
    logic [4:0]        expFlags [2];
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expData;
    logic [DATA_W-1:0] expRd [2];
    bit                expHasRd [2];

    task automatic modelEval();
        bit wr;
        int pA, pB;
        curG0 = 1'b0;
        curG1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                curG0 = (lastOwner == 1);
                curG1 = !curG0;
            end else begin
                curG0 = req0;
                curG1 = req1;
            end
        end
        wr      = (curG0 && we0) || (curG1 && we1);
        expAddr = reset ? '0 : (curG0 ? addr0 : (curG1 ? addr1 : holdAddr));
        expData = reset ? '0 : (curG0 ? wdata0 : (curG1 ? wdata1 : holdData));
        expHasRd[0] = !reset && retA.size() > 0 && retA[0].due == cyc;
        expHasRd[1] = !reset && retB.size() > 0 && retB[0].due == cyc;
        pA = expHasRd[0] ? retA[0].port : -1;
        pB = expHasRd[1] ? retB[0].port : -1;
        expRd[0] = expHasRd[0] ? retA[0].data : '0;
        expRd[1] = expHasRd[1] ? retB[0].data : '0;
        expFlags[0] = {curG0, curG1, wr, pA == 0, pA == 1};
        expFlags[1] = {curG0, curG1, wr, pB == 0, pB == 1};
    endtask

    task automatic modelCommit();
        int                p;
        logic [ADDR_W-1:0] a;
        if (reset) begin
            lastOwner = 1;
            holdAddr  = '0;
            holdData  = '0;
            retA.delete();
            retB.delete();
        end else begin
            if (expHasRd[0]) void'(retA.pop_front());
            if (expHasRd[1]) void'(retB.pop_front());
            if (curG0 || curG1) begin
                p         = curG1 ? 1 : 0;
                a         = curG1 ? addr1 : addr0;
                lastOwner = p;
                holdAddr  = a;
                holdData  = curG1 ? wdata1 : wdata0;
                if (curG1 ? we1 : we0) begin
                    refMem[a] = holdData;
                end else begin
                    retA.push_back(ret_t'{cyc + 1, p, refMem[a]});
                    retB.push_back(ret_t'{cyc + 3, p, refMem[a]});
                end
            end
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clock);
        modelEval();
    endtask

    task automatic advance();
        modelCommit();
        @(posedge clock);
        #1;
    endtask

    task automatic applyIdle();
        req0 = 1'b0;
        req1 = 1'b0;
        we0  = 1'b0;
        we1  = 1'b0;
    endtask

    task automatic doReset();
        applyIdle();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            advance();
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h0AA; wdata0 = 32'h1111_2222;
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h0BB; wdata1 = 32'h3333_4444;
        for (int i = 0; i < 3; i++) begin
            sample();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obsFlags[d] !== expFlags[d]) begin
                    miscompares++;
                    $display("[TB] FAIL reset_flags dut%0d cyc %0d: got %b expected %b", d, cyc, obsFlags[d], expFlags[d]);
                end
                vectors++;
                if ({obsAddr[d], obsData[d]} !== {expAddr, expData}) begin
                    miscompares++;
                    $display("[TB] FAIL reset_bus dut%0d cyc %0d: got %h/%h expected %h/%h", d, cyc, obsAddr[d], obsData[d], expAddr, expData);
                end
            end
            advance();
        end
        reset = 1'b0;
        applyIdle();
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 6; i++) begin
            applyIdle();
            if (i == 0) begin
                req0 = 1'b1; we0 = 1'b1; addr0 = 12'h010; wdata0 = 32'hDEAD_BEEF;
            end else if (i == 1) begin
                req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010; wdata0 = 32'h0;
            end
            sample();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obsFlags[d] !== expFlags[d]) begin
                    miscompares++;
                    $display("[TB] FAIL write_read_flags dut%0d cyc %0d: got %b expected %b", d, cyc, obsFlags[d], expFlags[d]);
                end
                vectors++;
                if ({obsAddr[d], obsData[d]} !== {expAddr, expData}) begin
                    miscompares++;
                    $display("[TB] FAIL write_read_bus dut%0d cyc %0d: got %h/%h expected %h/%h", d, cyc, obsAddr[d], obsData[d], expAddr, expData);
                end
                if (expHasRd[d]) begin
                    vectors++;
                    if ({obsRd0[d], obsRd1[d]} !== {expRd[d], expRd[d]}) begin
                        miscompares++;
                        $display("[TB] FAIL write_read_rdata dut%0d cyc %0d: got %h/%h expected %h", d, cyc, obsRd0[d], obsRd1[d], expRd[d]);
                    end
                end
            end
            advance();
        end
    endtask

    // Shared scenario runner body: stimulus chosen by mode and cycle index.
    task automatic setScenario(input int mode, input int i);
        applyIdle();
        case (mode)
            0: if (i < 6) begin
                   req0 = 1'b1; addr0 = 12'h001; req1 = 1'b1; addr1 = 12'h002;
               end
            1: begin
                   if (i < 6) begin req1 = 1'b1; addr1 = 12'(12'h040 + i); end
                   if (i >= 4 && i < 6) begin req0 = 1'b1; addr0 = 12'h050; end
               end
            2: begin
                   if (i == 0) begin req0 = 1'b1; addr0 = 12'h002; end
                   if (i == 1) begin
                       reset = 1'b1; req1 = 1'b1; we1 = 1'b1; addr1 = 12'h002; wdata1 = 32'hBAD0_BAD0;
                   end
                   if (i == 2) reset = 1'b0;
                   if (i == 6) begin req0 = 1'b1; addr0 = 12'h002; end
               end
            default: begin
                   if (i == 0) begin req0 = 1'b1; addr0 = 12'h003; end
                   if (i == 1) begin
                       req0 = 1'b1; we0 = 1'b1; addr0 = 12'h004; wdata0 = 32'hFEED_0004;
                       req1 = 1'b1; addr1 = 12'h005;
                   end
                   if (i == 2) begin req1 = 1'b1; addr1 = 12'h004; end
               end
        endcase
    endtask

    task automatic test_alternate();
        doReset();
        for (int i = 0; i < 10; i++) begin
            setScenario(0, i);
            sample();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obsFlags[d] !== expFlags[d]) begin
                    miscompares++;
                    $display("[TB] FAIL alternate_flags dut%0d cyc %0d: got %b expected %b", d, cyc, obsFlags[d], expFlags[d]);
                end
                vectors++;
                if ({obsAddr[d], obsData[d]} !== {expAddr, expData}) begin
                    miscompares++;
                    $display("[TB] FAIL alternate_bus dut%0d cyc %0d: got %h/%h expected %h/%h", d, cyc, obsAddr[d], obsData[d], expAddr, expData);
                end
                if (expHasRd[d]) begin
                    vectors++;
                    if ({obsRd0[d], obsRd1[d]} !== {expRd[d], expRd[d]}) begin
                        miscompares++;
                        $display("[TB] FAIL alternate_rdata dut%0d cyc %0d: got %h/%h expected %h", d, cyc, obsRd0[d], obsRd1[d], expRd[d]);
                    end
                end
            end
            advance();
        end
    endtask

    task automatic test_scenarios();
        for (int mode = 1; mode < 4; mode++) begin
            doReset();
            for (int i = 0; i < 10; i++) begin
                setScenario(mode, i);
                sample();
                for (int d = 0; d < 2; d++) begin
                    vectors++;
                    if (obsFlags[d] !== expFlags[d]) begin
                        miscompares++;
                        $display("[TB] FAIL scenario%0d_flags dut%0d cyc %0d: got %b expected %b", mode, d, cyc, obsFlags[d], expFlags[d]);
                    end
                    vectors++;
                    if ({obsAddr[d], obsData[d]} !== {expAddr, expData}) begin
                        miscompares++;
                        $display("[TB] FAIL scenario%0d_bus dut%0d cyc %0d: got %h/%h expected %h/%h", mode, d, cyc, obsAddr[d], obsData[d], expAddr, expData);
                    end
                    if (expHasRd[d]) begin
                        vectors++;
                        if ({obsRd0[d], obsRd1[d]} !== {expRd[d], expRd[d]}) begin
                            miscompares++;
                            $display("[TB] FAIL scenario%0d_rdata dut%0d cyc %0d: got %h/%h expected %h", mode, d, cyc, obsRd0[d], obsRd1[d], expRd[d]);
                        end
                    end
                end
                advance();
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 306; i++) begin
            if (i >= 300) begin
                applyIdle();
                reset = 1'b0;
            end else begin
                // A pending request stays stable until granted, unless randomly withdrawn.
                if (!req0 || curG0 || $urandom_range(0, 9) == 0) begin
                    req0   = ($urandom_range(0, 2) != 0);
                    we0    = 1'($urandom_range(0, 1));
                    addr0  = 12'($urandom_range(0, 15));
                    wdata0 = $urandom;
                end
                if (!req1 || curG1 || $urandom_range(0, 9) == 0) begin
                    req1   = ($urandom_range(0, 2) != 0);
                    we1    = 1'($urandom_range(0, 1));
                    addr1  = 12'($urandom_range(0, 15));
                    wdata1 = $urandom;
                end
                reset = ($urandom_range(0, 49) == 0);
            end
            sample();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obsFlags[d] !== expFlags[d]) begin
                    miscompares++;
                    $display("[TB] FAIL random_flags dut%0d cyc %0d: got %b expected %b", d, cyc, obsFlags[d], expFlags[d]);
                end
                vectors++;
                if ({obsAddr[d], obsData[d]} !== {expAddr, expData}) begin
                    miscompares++;
                    $display("[TB] FAIL random_bus dut%0d cyc %0d: got %h/%h expected %h/%h", d, cyc, obsAddr[d], obsData[d], expAddr, expData);
                end
                if (expHasRd[d]) begin
                    vectors++;
                    if ({obsRd0[d], obsRd1[d]} !== {expRd[d], expRd[d]}) begin
                        miscompares++;
                        $display("[TB] FAIL random_rdata dut%0d cyc %0d: got %h/%h expected %h", d, cyc, obsRd0[d], obsRd1[d], expRd[d]);
                    end
                end
            end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            refMem[i] = seedWord(i);
        end
        test_reset();
        test_write_read();
        test_alternate();
        test_scenarios();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
